// File: rtl/noc_adder_pkg.sv
// Shared types and helpers for the NoC adder demo: flit format, node IDs,
// and the Galois LFSR next-state function used by both operand sources.
package noc_adder_pkg;

  localparam int TDATAW = 32;

  // Node identifiers carried in the flit src field
  localparam logic [1:0] ADDER = 2'd0;
  localparam logic [1:0] SRC1  = 2'd1;
  localparam logic [1:0] SRC2  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [1:0]        src;
    logic [TDATAW-1:0] payload;
  } flit_t;

  // Galois LFSR step: shift right, fold in the feedback mask when bit 0 was set
  function automatic logic [TDATAW-1:0] lfsr_next(input logic [TDATAW-1:0] s,
                                                  input logic [TDATAW-1:0] poly);
    lfsr_next = (s >> 1) ^ (s[0] ? poly : '0);
  endfunction

endpackage

// File: rtl/noc_link.sv
// Fixed-latency NoC link: NOC_HOPS flit register stages, no backpressure.
// A flit presented at flit_in appears at flit_out NOC_HOPS edges later.
module noc_link
  import noc_adder_pkg::*;
#(
  parameter int NOC_HOPS = 3
) (
  input  logic  clk,
  input  logic  srst,
  input  flit_t flit_in,
  output flit_t flit_out
);

  // chain[0] is the link input, chain[gi+1] is the output of stage gi
  flit_t [NOC_HOPS:0] chain;

  assign chain[0] = flit_in;

  generate
    for (genvar gi = 0; gi < NOC_HOPS; gi++) begin : g_stage
      flit_t stage_reg;

      // One hop: advance the flit, reset flushes anything in flight
      always_ff @(posedge clk) begin
        if (srst) begin
          stage_reg <= '0;
        end else begin
          stage_reg <= chain[gi];
        end
      end

      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign flit_out = chain[NOC_HOPS];

endmodule

// File: rtl/noc_adder.sv
// NoC adder demo top: two LFSR operand sources, two forward links, an adder
// node and a return link. DONE pulses when the sum flit arrives back.
// Optional build macro NOC_ADDER_SATURATE_EN: saturate the sum on unsigned
// overflow instead of wrapping.
module noc_adder #(
  parameter int                    TDATAW    = noc_adder_pkg::TDATAW,
  parameter int                    NOC_HOPS  = 3,
  parameter logic [TDATAW-1:0]     SEED1     = 32'h0000_0001,
  parameter logic [TDATAW-1:0]     SEED2     = 32'h0000_0002,
  parameter logic [TDATAW-1:0]     LFSR_POLY = 32'h8020_0003
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              START2,
  output logic              DONE,
  output logic [TDATAW-1:0] DATA_O1,
  output logic [TDATAW-1:0] DATA_O2,
  output logic [TDATAW-1:0] RESULT
);
  import noc_adder_pkg::*;

  logic [TDATAW-1:0] s1_reg, s2_reg, data1_reg, data2_reg;
  logic [TDATAW-1:0] op_a_reg, op_b_reg, result_reg, sum_value;
  logic              busy1_reg, busy2_reg, flag_a_reg, flag_b_reg, done_reg;
  logic              accept1, accept2, result_arrives;
  flit_t             fwd1_in, fwd2_in, ret_in, fwd1_out, fwd2_out, ret_out;

  // A source only injects when it has no operand in flight
  assign accept1        = START  & ~busy1_reg;
  assign accept2        = START2 & ~busy2_reg;
  assign result_arrives = ret_out.valid && (ret_out.src == ADDER);

`ifdef NOC_ADDER_SATURATE_EN
  logic [TDATAW:0] sum_full;
  assign sum_full  = {1'b0, op_a_reg} + {1'b0, op_b_reg};
  assign sum_value = sum_full[TDATAW] ? '1 : sum_full[TDATAW-1:0];
`else
  assign sum_value = op_a_reg + op_b_reg;
`endif

  // Flit formation at each link entry; the return link's first stage is the sum register
  always_comb begin
    fwd1_in = '{valid: accept1, src: SRC1, payload: s1_reg};
    fwd2_in = '{valid: accept2, src: SRC2, payload: s2_reg};
    ret_in  = '{valid: flag_a_reg & flag_b_reg, src: ADDER, payload: sum_value};
  end

  noc_link #(.NOC_HOPS(NOC_HOPS)) u_fwd1 (
    .clk(CLK), .srst(RST), .flit_in(fwd1_in), .flit_out(fwd1_out)
  );

  noc_link #(.NOC_HOPS(NOC_HOPS)) u_fwd2 (
    .clk(CLK), .srst(RST), .flit_in(fwd2_in), .flit_out(fwd2_out)
  );

  noc_link #(.NOC_HOPS(NOC_HOPS)) u_ret (
    .clk(CLK), .srst(RST), .flit_in(ret_in), .flit_out(ret_out)
  );

  // Operand sources: inject on accepted start, go idle when the result returns
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_reg    <= SEED1;
      s2_reg    <= SEED2;
      data1_reg <= '0;
      data2_reg <= '0;
      busy1_reg <= 1'b0;
      busy2_reg <= 1'b0;
    end else begin
      if (accept1) begin
        data1_reg <= s1_reg;
        s1_reg    <= lfsr_next(s1_reg, LFSR_POLY);
        busy1_reg <= 1'b1;
      end
      if (accept2) begin
        data2_reg <= s2_reg;
        s2_reg    <= lfsr_next(s2_reg, LFSR_POLY);
        busy2_reg <= 1'b1;
      end
      if (result_arrives) begin
        busy1_reg <= 1'b0;
        busy2_reg <= 1'b0;
      end
    end
  end

  // Adder node: latch operands by source ID, consume both once the pair is complete
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      flag_a_reg <= 1'b0;
      flag_b_reg <= 1'b0;
    end else begin
      if (flag_a_reg && flag_b_reg) begin
        flag_a_reg <= 1'b0;
        flag_b_reg <= 1'b0;
      end
      if (fwd1_out.valid && (fwd1_out.src == SRC1)) begin
        op_a_reg   <= fwd1_out.payload;
        flag_a_reg <= 1'b1;
      end
      if (fwd2_out.valid && (fwd2_out.src == SRC2)) begin
        op_b_reg   <= fwd2_out.payload;
        flag_b_reg <= 1'b1;
      end
    end
  end

  // Result sink: hold the returned sum and pulse DONE for one cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      result_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= result_arrives;
      if (result_arrives) begin
        result_reg <= ret_out.payload;
      end
    end
  end

  assign DONE    = done_reg;
  assign DATA_O1 = data1_reg;
  assign DATA_O2 = data2_reg;
  assign RESULT  = result_reg;

endmodule

// File: tb/tb_noc_adder.sv
// Self-checking bench for noc_adder. Two instances share the start/reset
// stimulus: A with default seeds, B with SEED1=0xFFFF_FFFF to hit overflow.
// Expected operands, sums and DONE latency come from a transaction-level model.
module tb_noc_adder;

  localparam int          W    = 32;
  localparam int          H    = 3;
  localparam int          LAT  = 2 * H + 1;
  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] SEED1_A = 32'h0000_0001;
  localparam logic [31:0] SEED2_A = 32'h0000_0002;
  localparam logic [31:0] SEED1_B = 32'hFFFF_FFFF;
  localparam logic [31:0] SEED2_B = 32'h0000_0002;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic          done_a, done_b;
  logic [W-1:0]  d1_a, d2_a, res_a, d1_b, d2_b, res_b;

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = instance A, index 1 = instance B
  logic [31:0] m_s1 [2];
  logic [31:0] m_s2 [2];
  logic [31:0] m_d1 [2];
  logic [31:0] m_d2 [2];
  logic [31:0] m_res [2];
  bit          m_busy1, m_busy2;

  always #5 clk = ~clk;

  noc_adder #(.TDATAW(W), .NOC_HOPS(H), .SEED1(SEED1_A), .SEED2(SEED2_A), .LFSR_POLY(POLY)) dut_a (
    .CLK(clk), .RST(rst), .START(start), .START2(start2),
    .DONE(done_a), .DATA_O1(d1_a), .DATA_O2(d2_a), .RESULT(res_a)
  );

  noc_adder #(.TDATAW(W), .NOC_HOPS(H), .SEED1(SEED1_B), .SEED2(SEED2_B), .LFSR_POLY(POLY)) dut_b (
    .CLK(clk), .RST(rst), .START(start), .START2(start2),
    .DONE(done_b), .DATA_O1(d1_b), .DATA_O2(d2_b), .RESULT(res_b)
  );

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ POLY;
    return s >> 1;
  endfunction

  function automatic logic [31:0] sum_model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] full;
    full = {1'b0, a} + {1'b0, b};
`ifdef NOC_ADDER_SATURATE_EN
    if (full[32]) return 32'hFFFF_FFFF;
`endif
    return full[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_s1[0] = SEED1_A; m_s2[0] = SEED2_A;
    m_s1[1] = SEED1_B; m_s2[1] = SEED2_B;
    for (int k = 0; k < 2; k++) begin
      m_d1[k] = '0; m_d2[k] = '0; m_res[k] = '0;
    end
    m_busy1 = 1'b0;
    m_busy2 = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of start requests; the model accepts only idle sources
  task automatic inject(input bit b1, input bit b2);
    start  = b1;
    start2 = b2;
    if (b1 && !m_busy1) begin
      for (int k = 0; k < 2; k++) begin
        m_d1[k] = m_s1[k];
        m_s1[k] = lfsr_step(m_s1[k]);
      end
      m_busy1 = 1'b1;
    end
    if (b2 && !m_busy2) begin
      for (int k = 0; k < 2; k++) begin
        m_d2[k] = m_s2[k];
        m_s2[k] = lfsr_step(m_s2[k]);
      end
      m_busy2 = 1'b1;
    end
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Model side of a completed transaction
  task automatic model_complete();
    for (int k = 0; k < 2; k++) m_res[k] = sum_model(m_d1[k], m_d2[k]);
    m_busy1 = 1'b0;
    m_busy2 = 1'b0;
  endtask

  // Bounded wait for DONE; lat = cycles elapsed, -1 if the budget ran out
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done_a) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    total++;
    if ({done_a, d1_a, d2_a, res_a} !== '0) begin
      bad++;
      $display("FAIL reset_a: got done=%b d1=%h d2=%h res=%h want all zero", done_a, d1_a, d2_a, res_a);
    end
    total++;
    if ({done_b, d1_b, d2_b, res_b} !== '0) begin
      bad++;
      $display("FAIL reset_b: got done=%b d1=%h d2=%h res=%h want all zero", done_b, d1_b, d2_b, res_b);
    end
    rst = 1'b0;
    model_reset();
    $display("txn reset: outputs a=%h/%h/%h b=%h/%h/%h", d1_a, d2_a, res_a, d1_b, d2_b, res_b);
  endtask

  // START at edge 0, START2 at edge 1 (or reversed): DONE 2H+1 after the later one
  task automatic test_staggered(input string name, input bit src1_first);
    int lat;
    if (src1_first) begin
      inject(1'b1, 1'b0);
      inject(1'b0, 1'b1);
    end else begin
      inject(1'b0, 1'b1);
      inject(1'b1, 1'b0);
    end
    total++;
    if (d1_a !== m_d1[0] || d2_a !== m_d2[0]) begin
      bad++;
      $display("FAIL %s_operands_a: got %h,%h want %h,%h", name, d1_a, d2_a, m_d1[0], m_d2[0]);
    end
    total++;
    if (d1_b !== m_d1[1] || d2_b !== m_d2[1]) begin
      bad++;
      $display("FAIL %s_operands_b: got %h,%h want %h,%h", name, d1_b, d2_b, m_d1[1], m_d2[1]);
    end
    wait_done(3 * LAT, lat);
    model_complete();
    total++;
    if (lat != LAT) begin
      bad++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, LAT);
    end
    total++;
    if (res_a !== m_res[0] || done_b !== 1'b1 || res_b !== m_res[1]) begin
      bad++;
      $display("FAIL %s_result: got a=%h b=%h done_b=%b want a=%h b=%h done_b=1",
               name, res_a, res_b, done_b, m_res[0], m_res[1]);
    end
    tick();
    total++;
    if (done_a !== 1'b0 || done_b !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_width: got done=%b/%b want 0/0", name, done_a, done_b);
    end
    $display("txn %s: a=%h+%h=%h b=%h+%h=%h lat=%0d", name, d1_a, d2_a, res_a, d1_b, d2_b, res_b, lat);
  endtask

  // Both starts together, then START again while busy: ignored, single DONE
  task automatic test_same_cycle_repeat();
    int lat;
    int extra;
    inject(1'b1, 1'b1);
    tick();
    inject(1'b1, 1'b0);
    total++;
    if (d1_a !== m_d1[0] || d1_b !== m_d1[1]) begin
      bad++;
      $display("FAIL busy_start_ignored: got d1=%h/%h want %h/%h", d1_a, d1_b, m_d1[0], m_d1[1]);
    end
    wait_done(3 * LAT, lat);
    model_complete();
    total++;
    if (lat != LAT - 2) begin
      bad++;
      $display("FAIL same_cycle_latency: got %0d want %0d", lat, LAT - 2);
    end
    total++;
    if (res_a !== m_res[0] || res_b !== m_res[1]) begin
      bad++;
      $display("FAIL same_cycle_result: got %h/%h want %h/%h", res_a, res_b, m_res[0], m_res[1]);
    end
    extra = 0;
    repeat (20) begin
      tick();
      if (done_a || done_b) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL single_done: got %0d extra DONE cycles want 0", extra);
    end
    $display("txn same_cycle: res=%h/%h lat=%0d extra=%0d", res_a, res_b, lat + 2, extra);
  endtask

  // A start presented while DONE is high must be accepted
  task automatic test_back_to_back();
    int lat;
    inject(1'b1, 1'b1);
    wait_done(3 * LAT, lat);
    model_complete();
    inject(1'b1, 1'b1);
    total++;
    if (d1_a !== m_d1[0] || d2_a !== m_d2[0] || d1_b !== m_d1[1]) begin
      bad++;
      $display("FAIL b2b_accept: got %h,%h,%h want %h,%h,%h", d1_a, d2_a, d1_b, m_d1[0], m_d2[0], m_d1[1]);
    end
    wait_done(3 * LAT, lat);
    model_complete();
    total++;
    if (lat != LAT || res_a !== m_res[0] || res_b !== m_res[1]) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d res=%h/%h want lat=%0d res=%h/%h",
               lat, res_a, res_b, LAT, m_res[0], m_res[1]);
    end
    $display("txn back_to_back: res=%h/%h lat=%0d", res_a, res_b, lat);
  endtask

  // Reset three cycles into a transaction: flush, no DONE, seeds restored
  task automatic test_reset_midflight();
    int lat;
    int seen;
    inject(1'b1, 1'b1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    total++;
    if ({done_a, d1_a, d2_a, res_a, done_b, d1_b, d2_b, res_b} !== '0) begin
      bad++;
      $display("FAIL midflight_outputs: got d1=%h d2=%h res=%h b_res=%h want zeros", d1_a, d2_a, res_a, res_b);
    end
    seen = 0;
    repeat (20) begin
      tick();
      if (done_a || done_b) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midflight_no_done: got %0d DONE cycles want 0", seen);
    end
    inject(1'b1, 1'b1);
    wait_done(3 * LAT, lat);
    model_complete();
    total++;
    if (lat != LAT || res_a !== 32'h0000_0003 || res_b !== m_res[1]) begin
      bad++;
      $display("FAIL midflight_recover: got lat=%0d res=%h/%h want lat=%0d res=00000003/%h",
               lat, res_a, res_b, LAT, m_res[1]);
    end
    $display("txn reset_midflight: res=%h/%h lat=%0d", res_a, res_b, lat);
  endtask

  // Random order, separation and busy re-presses against the model
  task automatic test_random(input int count);
    int lat;
    int gap;
    bit first1;
    for (int t = 0; t < count; t++) begin
      gap    = $urandom_range(0, 4);
      first1 = 1'($urandom_range(0, 1));
      if (gap == 0) begin
        inject(1'b1, 1'b1);
      end else begin
        inject(first1, !first1);
        for (int g = 1; g < gap; g++) begin
          if ($urandom_range(0, 1) == 1) inject(first1, !first1);
          else inject(1'b0, 1'b0);
        end
        inject(!first1, first1);
      end
      wait_done(3 * LAT, lat);
      model_complete();
      total++;
      if (lat != LAT || d1_a !== m_d1[0] || d2_a !== m_d2[0] || res_a !== m_res[0] || res_b !== m_res[1]) begin
        bad++;
        $display("FAIL random_%0d: got lat=%0d a=%h+%h=%h b=%h want lat=%0d a=%h+%h=%h b=%h",
                 t, lat, d1_a, d2_a, res_a, res_b, LAT, m_d1[0], m_d2[0], m_res[0], m_res[1]);
      end
      $display("txn random_%0d: gap=%0d a=%h+%h=%h b=%h lat=%0d", t, gap, d1_a, d2_a, res_a, res_b, lat);
      tick();
    end
  endtask

  // Only source 1 ever starts: the adder must keep waiting
  task automatic test_only_start();
    int seen;
    do_reset(2);
    inject(1'b1, 1'b0);
    seen = 0;
    repeat (50) begin
      tick();
      if (done_a || done_b) seen++;
    end
    total++;
    if (seen != 0 || d1_a !== m_d1[0] || res_a !== m_res[0]) begin
      bad++;
      $display("FAIL only_start: got done_cycles=%0d d1=%h res=%h want 0 %h %h", seen, d1_a, res_a, m_d1[0], m_res[0]);
    end
    $display("txn only_start: done_cycles=%0d d1=%h", seen, d1_a);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_staggered("first", 1'b1);
    test_staggered("second", 1'b0);
    total++;
    if (d1_a !== 32'h8020_0003 || d2_a !== 32'h0000_0001 || res_a !== 32'h8020_0004) begin
      bad++;
      $display("FAIL second_values: got %h,%h,%h want 80200003,00000001,80200004", d1_a, d2_a, res_a);
    end
    test_same_cycle_repeat();
    test_back_to_back();
    test_reset_midflight();
    test_random(12);
    test_only_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
